// File: rtl/order_book_hls_deadlock_watchdog.sv
// Deadlock watchdog for HLS order-book instances: debounces AXIS/instance block conditions into block/block_sticky.
// Optional diagnostics (first_chan, block_cycles) are built only when ORDER_BOOK_DEADLOCK_DIAG_EN is defined.
module order_book_hls_deadlock_watchdog #(
    parameter int NUM_AXIS    = 7,
    parameter int NUM_INST    = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1),
    parameter int IDX_W       = $clog2(NUM_AXIS + 1)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic                clear,
    output logic                block,
    output logic                block_sticky,
    output logic [IDX_W-1:0]    first_chan,
    output logic [15:0]         block_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_BLOCKED = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             block_q, block_d;
    logic             sticky_q, sticky_d;

    logic axisHit;
    logic instHit;
    logic cond;
    logic enterBlocked;
    logic stayBlocked;
    logic capture;

    assign axisHit = |axis_block_sigs;
    assign instHit = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
    assign cond    = axisHit | instHit;
    assign capture = (state_q == ST_IDLE) && cond;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        enterBlocked = 1'b0;
        stayBlocked  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (cond) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d      = ST_BLOCKED;
                        enterBlocked = 1'b1;
                    end else begin
                        state_d = ST_SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            ST_SUSPECT: begin
                // A single quiet edge restarts the whole hold window.
                if (!cond) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
                    state_d      = ST_BLOCKED;
                    cnt_d        = '0;
                    enterBlocked = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_BLOCKED: begin
                cnt_d = '0;
                if (cond) begin
                    stayBlocked = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Setting the sticky flag takes priority over a simultaneous clear.
    always_comb begin
        block_d  = (state_d == ST_BLOCKED);
        sticky_d = sticky_q;
        if (enterBlocked || stayBlocked) begin
            sticky_d = 1'b1;
        end else if (clear) begin
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            block_q  <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            block_q  <= block_d;
            sticky_q <= sticky_d;
        end
    end

    assign block        = block_q;
    assign block_sticky = sticky_q;

`ifdef ORDER_BOOK_DEADLOCK_DIAG_EN
    logic [IDX_W-1:0] firstChan_q, firstChan_d;
    logic [15:0]      blockCycles_q, blockCycles_d;
    logic [IDX_W-1:0] lowIdx;

    // NUM_AXIS encodes "no AXIS channel involved, instance-only cause".
    always_comb begin
        lowIdx = IDX_W'(NUM_AXIS);
        for (int i = NUM_AXIS - 1; i >= 0; i--) begin
            if (axis_block_sigs[i]) begin
                lowIdx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        firstChan_d   = firstChan_q;
        blockCycles_d = blockCycles_q;
        if (capture) begin
            firstChan_d = lowIdx;
        end else if (clear) begin
            firstChan_d = '0;
        end
        if (enterBlocked) begin
            blockCycles_d = '0;
        end else if (clear && !stayBlocked) begin
            blockCycles_d = '0;
        end else if ((state_q == ST_BLOCKED) && (blockCycles_q != 16'hFFFF)) begin
            blockCycles_d = blockCycles_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            firstChan_q   <= '0;
            blockCycles_q <= '0;
        end else begin
            firstChan_q   <= firstChan_d;
            blockCycles_q <= blockCycles_d;
        end
    end

    assign first_chan   = firstChan_q;
    assign block_cycles = blockCycles_q;
`else
    logic unusedCapture;
    assign unusedCapture = capture;
    assign first_chan    = '0;
    assign block_cycles  = '0;
`endif

endmodule

// File: tb/tb_order_book_hls_deadlock_watchdog.sv
// Randomized self-checking bench for order_book_hls_deadlock_watchdog (HOLD_CYCLES=1 and HOLD_CYCLES=4 instances).
// The reference model tracks the length of the current run of deadlock-condition edges.
module tb_order_book_hls_deadlock_watchdog;

    logic       clock;
    logic       reset;
    logic [6:0] axisSigs;
    logic [0:0] idleA, blockA;
    logic [1:0] idleB, blockB;
    logic       clr;

    logic        blkA, stickyA, blkB, stickyB;
    logic [2:0]  fcA, fcB;
    logic [15:0] bcA, bcB;

    int nCompared   = 0;
    int nMismatched = 0;

    int holdOf[2] = '{1, 4};
    int runLen[2];
    int expSticky[2];
    int expFc[2];
    int expBc[2];

    order_book_hls_deadlock_watchdog #(
        .NUM_AXIS(7), .NUM_INST(1), .HOLD_CYCLES(1)
    ) dutA (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axisSigs), .inst_idle_sigs(idleA), .inst_block_sigs(blockA),
        .clear(clr), .block(blkA), .block_sticky(stickyA),
        .first_chan(fcA), .block_cycles(bcA)
    );

    order_book_hls_deadlock_watchdog #(
        .NUM_AXIS(7), .NUM_INST(2), .HOLD_CYCLES(4)
    ) dutB (
        .clock(clock), .reset(reset),
        .axis_block_sigs(axisSigs), .inst_idle_sigs(idleB), .inst_block_sigs(blockB),
        .clear(clr), .block(blkB), .block_sticky(stickyB),
        .first_chan(fcB), .block_cycles(bcB)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nCompared++;
        if (observed !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            runLen[d]    = 0;
            expSticky[d] = 0;
            expFc[d]     = 0;
            expBc[d]     = 0;
        end
    endtask

    // One clock edge of the behavioural model for instance d.
    task automatic modelStep(input int d, input bit condV, input int lowIdx, input bit clrV);
        bit wasBlocked, isBlocked;
        wasBlocked = runLen[d] >= holdOf[d];
        if (condV) begin
            if (runLen[d] < 1000000) runLen[d]++;
        end else begin
            runLen[d] = 0;
        end
        isBlocked = runLen[d] >= holdOf[d];
        if (isBlocked) expSticky[d] = 1;
        else if (clrV) expSticky[d] = 0;
        if (isBlocked && !wasBlocked) expBc[d] = 0;
        else if (clrV && !(isBlocked && wasBlocked)) expBc[d] = 0;
        else if (wasBlocked && expBc[d] < 65535) expBc[d]++;
        if (runLen[d] == 1) expFc[d] = lowIdx;
        else if (clrV) expFc[d] = 0;
    endtask

    task automatic checkAll(input bit fullDiag);
        checkOutput("blockA",  32'(blkA),    32'(runLen[0] >= holdOf[0]));
        checkOutput("stickyA", 32'(stickyA), 32'(expSticky[0]));
        checkOutput("blockB",  32'(blkB),    32'(runLen[1] >= holdOf[1]));
        checkOutput("stickyB", 32'(stickyB), 32'(expSticky[1]));
        if (fullDiag) begin
`ifdef ORDER_BOOK_DEADLOCK_DIAG_EN
            checkOutput("firstChanA",   32'(fcA), 32'(expFc[0]));
            checkOutput("blockCyclesA", 32'(bcA), 32'(expBc[0]));
            checkOutput("firstChanB",   32'(fcB), 32'(expFc[1]));
            checkOutput("blockCyclesB", 32'(bcB), 32'(expBc[1]));
`else
            checkOutput("firstChanA",   32'(fcA), 32'd0);
            checkOutput("blockCyclesA", 32'(bcA), 32'd0);
            checkOutput("firstChanB",   32'(fcB), 32'd0);
            checkOutput("blockCyclesB", 32'(bcB), 32'd0);
`endif
        end
    endtask

    task automatic applyStimulus(input logic [6:0] ax, input logic iA, input logic bA,
                                 input logic [1:0] iB, input logic [1:0] bB, input logic c,
                                 input bit fullDiag);
        int  lowIdx;
        bit  axisHit, condA, condB;
        axisSigs = ax;
        idleA    = iA;
        blockA   = bA;
        idleB    = iB;
        blockB   = bB;
        clr      = c;
        @(posedge clock);
        #1;
        axisHit = (ax != 7'd0);
        lowIdx  = 7;
        for (int i = 6; i >= 0; i--) if (ax[i]) lowIdx = i;
        condA = axisHit || ((iA | bA) == 1'b1 && bA == 1'b1);
        condB = axisHit || ((iB | bB) == 2'b11 && bB != 2'b00);
        modelStep(0, condA, lowIdx, c);
        modelStep(1, condB, lowIdx, c);
        checkAll(fullDiag);
    endtask

    task automatic quiet(input int n);
        for (int k = 0; k < n; k++) applyStimulus(7'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_blockA"},  32'(blkA),    32'd0);
        checkOutput({tag, "_stickyA"}, 32'(stickyA), 32'd0);
        checkOutput({tag, "_fcA"},     32'(fcA),     32'd0);
        checkOutput({tag, "_bcA"},     32'(bcA),     32'd0);
        checkOutput({tag, "_blockB"},  32'(blkB),    32'd0);
        checkOutput({tag, "_stickyB"}, 32'(stickyB), 32'd0);
        checkOutput({tag, "_fcB"},     32'(fcB),     32'd0);
        checkOutput({tag, "_bcB"},     32'(bcB),     32'd0);
    endtask

    task automatic asyncReset(input string tag);
        #3;
        reset = 1'b0;
        #1;
        checkAllZero(tag);
        modelReset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [6:0] ax;
        logic [1:0] iB, bB;
        logic       iA, bA;
        int         mode, onLen;

        reset    = 1'b0;
        axisSigs = '0;
        idleA    = '0;
        blockA   = '0;
        idleB    = '0;
        blockB   = '0;
        clr      = 1'b0;
        modelReset();
        repeat (3) @(posedge clock);
        #1;
        checkAllZero("reset");
        @(negedge clock);
        reset = 1'b1;

        $display("[TB] single-cycle AXIS pulse on channel 2");
        applyStimulus(7'b0000100, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        quiet(3);

        $display("[TB] channel 5: three edges then four edges");
        for (int k = 0; k < 3; k++) applyStimulus(7'b0100000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        quiet(1);
        for (int k = 0; k < 4; k++) applyStimulus(7'b0100000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        quiet(2);

        $display("[TB] instance-only causes");
        for (int k = 0; k < 6; k++) applyStimulus(7'd0, 1'b0, 1'b1, 2'b01, 2'b10, 1'b0, 1'b1);
        quiet(1);
        for (int k = 0; k < 6; k++) applyStimulus(7'd0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 1'b1);
        quiet(1);

        $display("[TB] clear coinciding with BLOCKED entry");
        applyStimulus(7'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) applyStimulus(7'b0001000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        applyStimulus(7'b0001000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        applyStimulus(7'b0001000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        quiet(2);

        $display("[TB] randomized segments");
        for (int seg = 0; seg < 300; seg++) begin
            mode  = $urandom_range(0, 2);
            onLen = $urandom_range(1, 7);
            for (int k = 0; k < onLen; k++) begin
                ax = 7'($urandom);
                iA = 1'($urandom);
                bA = 1'($urandom);
                iB = 2'($urandom);
                bB = 2'($urandom);
                if (mode == 1) ax = 7'd0;
                if (mode == 2) begin
                    ax = 7'd0;
                    bA = 1'b0;
                    bB = 2'b00;
                end
                applyStimulus(ax, iA, bA, iB, bB, ($urandom_range(0, 15) == 0), 1'b1);
            end
            if ($urandom_range(0, 1) == 1) quiet($urandom_range(1, 3));
        end

        $display("[TB] reset mid-SUSPECT and mid-BLOCKED");
        quiet(2);
        for (int k = 0; k < 2; k++) applyStimulus(7'b0000010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        asyncReset("rstSuspect");
        for (int k = 0; k < 4; k++) applyStimulus(7'b0000010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) applyStimulus(7'b0000010, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        asyncReset("rstBlocked");
        for (int k = 0; k < 5; k++) applyStimulus(7'b1000000, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1);
        quiet(2);

        $display("[TB] long BLOCKED run for saturation");
        for (int k = 0; k < 70000; k++) applyStimulus(7'b0000001, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, (k % 1000) == 999);
        checkAll(1'b1);
        quiet(2);
        applyStimulus(7'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1);
        quiet(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
